// File: rtl/audio_out_fifo_if.sv
// Sample path between the register file (master) and the audio output FIFO (slave).
// The master drives R6_audio/R14_flag and reads R13_flag plus the DAC-facing outputs.
interface audio_out_fifo_if #(
  parameter int DATA_W = 11
);
  logic [DATA_W-1:0] sample_in;
  logic              push_flag;
  logic              full_flag;
  logic [DATA_W-1:0] audio_out;
  logic              audio_valid;

  modport master (
    output sample_in,
    output push_flag,
    input  full_flag,
    input  audio_out,
    input  audio_valid
  );

  modport slave (
    input  sample_in,
    input  push_flag,
    output full_flag,
    output audio_out,
    output audio_valid
  );
endinterface

// File: rtl/audio_out_fifo.sv
// Audio output FIFO: captures one sample per rising edge of the push strobe and
// releases one sample per CLK_DIV clocks to the DAC, with sticky overflow/underrun.
module audio_out_fifo #(
  parameter int DATA_W  = 11,
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 2268
) (
  input  logic                   clk,
  input  logic                   rst,
  audio_out_fifo_if.slave        bus,
  input  logic                   clr_err,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLK_DIV);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     tick_cnt;
  logic              push_q;

  logic              push_req;
  logic              tick;
  logic              is_full;
  logic              is_empty;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [LW-1:0]     level_next;

  assign push_req = bus.push_flag & ~push_q;
  assign tick     = (tick_cnt == CW'(CLK_DIV - 1));
  assign is_full  = (level == LW'(DEPTH));
  assign is_empty = (level == '0);
  assign pop      = tick & ~is_empty;
  // A full FIFO still accepts a push when the same cycle pops the head.
  assign push_ok  = push_req & (~is_full | pop);
  assign drop     = push_req & is_full & ~pop;

  always_comb begin
    level_next = level;
    case ({push_ok, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_q          <= 1'b0;
      tick_cnt        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      bus.full_flag   <= 1'b0;
      bus.audio_out   <= '0;
      bus.audio_valid <= 1'b0;
      overflow        <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      push_q          <= bus.push_flag;
      tick_cnt        <= tick ? '0 : tick_cnt + CW'(1);
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        bus.audio_out <= mem[rd_ptr];
      end
      level           <= level_next;
      bus.full_flag   <= (level_next == LW'(DEPTH));
      bus.audio_valid <= pop;
      // Error set takes priority over a simultaneous clear.
      overflow        <= drop | (overflow & ~clr_err);
      underrun        <= (tick & is_empty) | (underrun & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= bus.sample_in;
  end

endmodule
